segre_mem_arbiter: RTL and testbench

- Parametrised N-port arbiter between several memory requestors (fetch, LSU, debug/DMA) and one shared memory port of the core/memory handshake type (rd/wr strobes, addr, wr data, data type, ready).
- Successor to the single-requestor core-to-memory hookup.
- Adds round-robin arbitration over N_PORTS, registered request capture, and a watchdog timeout on memory ready.

---
 rtl/segre_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_segre_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_arbiter.sv
// Round-robin arbiter from N requestor ports onto one core/memory handshake port.
// Requests are captured into registered mem_* outputs; a watchdog aborts a stalled access.
module segre_mem_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DTYPE_W = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic [N_PORTS-1:0]           req_rd_i,
  input  logic [N_PORTS-1:0]           req_wr_i,
  input  logic [N_PORTS*ADDR_W-1:0]    req_addr_i,
  input  logic [N_PORTS*DATA_W-1:0]    req_wr_data_i,
  input  logic [N_PORTS*DTYPE_W-1:0]   req_data_type_i,
  output logic [N_PORTS-1:0]           req_ready_o,
  output logic                         req_err_o,
  output logic [DATA_W-1:0]            req_rd_data_o,
  output logic                         mem_rd_o,
  output logic                         mem_wr_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wr_data_o,
  output logic [DTYPE_W-1:0]           mem_data_type_o,
  input  logic [DATA_W-1:0]            mem_rd_data_i,
  input  logic                         mem_ready_i
);

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [CNT_W-1:0]     wd_q, wd_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wr_data_q, mem_wr_data_d;
  logic [DTYPE_W-1:0]   mem_data_type_q, mem_data_type_d;

  logic [N_PORTS-1:0]   req_any;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  int unsigned          cand;
  logic                 wd_hit;

  assign req_any = req_rd_i | req_wr_i;
  assign wd_hit  = (TIMEOUT != 0) && (wd_q == CNT_LAST);

  // Scan starts just past the last grant, so the most recent winner is tried last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = 0;
    for (int unsigned i = 1; i <= N_PORTS; i++) begin
      cand = (int'(last_q) + i) % N_PORTS;
      if (!win_found && req_any[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    grant_d         = grant_q;
    wd_d            = wd_q;
    mem_rd_d        = mem_rd_q;
    mem_wr_d        = mem_wr_q;
    mem_addr_d      = mem_addr_q;
    mem_wr_data_d   = mem_wr_data_q;
    mem_data_type_d = mem_data_type_q;
    req_ready_o     = '0;
    req_err_o       = 1'b0;
    req_rd_data_o   = '0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (win_found) begin
          grant_d         = win_idx;
          last_d          = win_idx;
          mem_wr_d        = req_wr_i[win_idx];
          mem_rd_d        = req_rd_i[win_idx] & ~req_wr_i[win_idx];
          mem_addr_d      = req_addr_i[win_idx*ADDR_W +: ADDR_W];
          mem_wr_data_d   = req_wr_data_i[win_idx*DATA_W +: DATA_W];
          mem_data_type_d = req_data_type_i[win_idx*DTYPE_W +: DTYPE_W];
          state_d         = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready_i || wd_hit) begin
          // Ready takes precedence over a coincident watchdog expiry.
          req_ready_o[grant_q] = 1'b1;
          req_err_o            = ~mem_ready_i;
          req_rd_data_o        = mem_ready_i ? mem_rd_data_i : '0;
          mem_rd_d             = 1'b0;
          mem_wr_d             = 1'b0;
          wd_d                 = '0;
          state_d              = IDLE;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q         <= IDLE;
      last_q          <= IDX_W'(N_PORTS - 1);
      grant_q         <= '0;
      wd_q            <= '0;
      mem_rd_q        <= 1'b0;
      mem_wr_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wr_data_q   <= '0;
      mem_data_type_q <= '0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      grant_q         <= grant_d;
      wd_q            <= wd_d;
      mem_rd_q        <= mem_rd_d;
      mem_wr_q        <= mem_wr_d;
      mem_addr_q      <= mem_addr_d;
      mem_wr_data_q   <= mem_wr_data_d;
      mem_data_type_q <= mem_data_type_d;
    end
  end

  assign mem_rd_o        = mem_rd_q;
  assign mem_wr_o        = mem_wr_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wr_data_o   = mem_wr_data_q;
  assign mem_data_type_o = mem_data_type_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: a 2-port instance (TIMEOUT=8) and a 4-port
// instance for round-robin fairness.
module tb_segre_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rsn;
  logic [1:0]   rd2, wr2, rdy2;
  logic [63:0]  addr2, wdata2;
  logic [3:0]   type2;
  logic         err2, mrd2, mwr2, mready2;
  logic [31:0]  rdata2, maddr2, mwdata2, mrdata2;
  logic [1:0]   mtype2;

  logic [3:0]   rd4, wr4, rdy4;
  logic [127:0] addr4, wdata4;
  logic [7:0]   type4;
  logic         err4, mrd4, mwr4, mready4;
  logic [31:0]  rdata4, maddr4, mwdata4, mrdata4;
  logic [1:0]   mtype4;

  int n_cmp = 0;
  int n_bad = 0;

  segre_mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .DTYPE_W(2), .TIMEOUT(8)) dut2 (
    .clk_i(clk), .rsn_i(rsn), .req_rd_i(rd2), .req_wr_i(wr2), .req_addr_i(addr2),
    .req_wr_data_i(wdata2), .req_data_type_i(type2), .req_ready_o(rdy2), .req_err_o(err2),
    .req_rd_data_o(rdata2), .mem_rd_o(mrd2), .mem_wr_o(mwr2), .mem_addr_o(maddr2),
    .mem_wr_data_o(mwdata2), .mem_data_type_o(mtype2), .mem_rd_data_i(mrdata2),
    .mem_ready_i(mready2));

  segre_mem_arbiter #(.N_PORTS(4)) dut4 (
    .clk_i(clk), .rsn_i(rsn), .req_rd_i(rd4), .req_wr_i(wr4), .req_addr_i(addr4),
    .req_wr_data_i(wdata4), .req_data_type_i(type4), .req_ready_o(rdy4), .req_err_o(err4),
    .req_rd_data_o(rdata4), .mem_rd_o(mrd4), .mem_wr_o(mwr4), .mem_addr_o(maddr4),
    .mem_wr_data_o(mwdata4), .mem_data_type_o(mtype4), .mem_rd_data_i(mrdata4),
    .mem_ready_i(mready4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rsn = 1'b0;
    rd2 = '0; wr2 = '0; addr2 = '0; wdata2 = '0; type2 = '0; mrdata2 = '0; mready2 = 1'b0;
    rd4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0; type4 = '0; mrdata4 = '0; mready4 = 1'b0;
    tick();
    tick();
    rsn = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    rsn = 1'b0;
    rd2 = 2'b11;
    rd4 = 4'hF;
    mready2 = 1'b1;
    tick();
    tick();
    #1;
    n_cmp++;
    if ({mrd2, mwr2, maddr2, mwdata2, mtype2, rdy2, err2, rdata2} !== '0) begin
      n_bad++;
      $display("FAIL reset_dut2: got rd=%b wr=%b addr=%h rdy=%b err=%b want all 0", mrd2, mwr2, maddr2, rdy2, err2);
    end
    n_cmp++;
    if ({mrd4, mwr4, maddr4, rdy4, err4, rdata4} !== '0) begin
      n_bad++;
      $display("FAIL reset_dut4: got rd=%b addr=%h rdy=%b want all 0", mrd4, maddr4, rdy4);
    end
    do_reset();
  endtask

  task automatic test_single_read;
    do_reset();
    rd2 = 2'b10;
    addr2[63:32] = 32'h100;
    type2[3:2] = 2'b10;
    #1;
    n_cmp++;
    if (mrd2 !== 1'b0) begin
      n_bad++; $display("FAIL sr_strobe_t0: got %b want 0", mrd2);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin mready2 = 1'b1; mrdata2 = 32'hDEADBEEF; end
      #1;
      n_cmp++;
      if ({mrd2, mwr2, maddr2} !== {1'b1, 1'b0, 32'h100}) begin
        n_bad++; $display("FAIL sr_mem c%0d: got rd=%b wr=%b addr=%h want 1 0 00000100", c, mrd2, mwr2, maddr2);
      end
      n_cmp++;
      if (rdy2 !== ((c == 3) ? 2'b10 : 2'b00)) begin
        n_bad++; $display("FAIL sr_ready c%0d: got %b want %b", c, rdy2, (c == 3) ? 2'b10 : 2'b00);
      end
      n_cmp++;
      if ({err2, rdata2} !== {1'b0, (c == 3) ? 32'hDEADBEEF : 32'h0}) begin
        n_bad++; $display("FAIL sr_data c%0d: got err=%b data=%h", c, err2, rdata2);
      end
    end
    tick();
    mready2 = 1'b0;
    rd2 = 2'b00;
    #1;
    n_cmp++;
    if ({mrd2, rdy2} !== 3'b000) begin
      n_bad++; $display("FAIL sr_after: got rd=%b rdy=%b want 0 00", mrd2, rdy2);
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    rd2 = 2'b11;
    addr2 = {32'h20, 32'h10};
    tick();
    mready2 = 1'b1;
    #1;
    n_cmp++;
    if ({rdy2, maddr2} !== {2'b01, 32'h10}) begin
      n_bad++; $display("FAIL sim_first: got rdy=%b addr=%h want 01 00000010", rdy2, maddr2);
    end
    tick();
    rd2 = 2'b10;
    #1;
    n_cmp++;
    if ({mrd2, rdy2} !== 3'b000) begin
      n_bad++; $display("FAIL sim_bubble: got rd=%b rdy=%b want 0 00", mrd2, rdy2);
    end
    tick();
    #1;
    n_cmp++;
    if ({rdy2, maddr2} !== {2'b10, 32'h20}) begin
      n_bad++; $display("FAIL sim_second: got rdy=%b addr=%h want 10 00000020", rdy2, maddr2);
    end
    tick();
    rd2 = 2'b00;
    mready2 = 1'b0;
  endtask

  task automatic test_fairness;
    logic [3:0] exp_rdy;
    do_reset();
    rd4 = 4'hF;
    addr4 = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    mready4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      tick();
      #1;
      n_cmp++;
      if ({rdy4, maddr4} !== {exp_rdy, 32'h1000 + 32'(k % 4)}) begin
        n_bad++; $display("FAIL fair_grant%0d: got rdy=%b addr=%h want %b", k, rdy4, maddr4, exp_rdy);
      end
      tick();
      #1;
      n_cmp++;
      if (rdy4 !== 4'b0000) begin
        n_bad++; $display("FAIL fair_bubble%0d: got %b want 0000", k, rdy4);
      end
    end
    rd4 = '0;
    mready4 = 1'b0;
    tick();
  endtask

  task automatic test_write_priority;
    do_reset();
    rd2 = 2'b01;
    wr2 = 2'b01;
    addr2[31:0] = 32'h40;
    wdata2[31:0] = 32'h12345678;
    type2[1:0] = 2'b10;
    tick();
    #1;
    n_cmp++;
    if ({mwr2, mrd2, mwdata2, maddr2, mtype2} !== {1'b1, 1'b0, 32'h12345678, 32'h40, 2'b10}) begin
      n_bad++; $display("FAIL wp_mem: got wr=%b rd=%b wdata=%h addr=%h type=%b", mwr2, mrd2, mwdata2, maddr2, mtype2);
    end
    mready2 = 1'b1;
    #1;
    n_cmp++;
    if ({rdy2, err2} !== 3'b010) begin
      n_bad++; $display("FAIL wp_ready: got rdy=%b err=%b want 01 0", rdy2, err2);
    end
    tick();
    rd2 = '0; wr2 = '0; mready2 = 1'b0;
    #1;
    n_cmp++;
    if (mwr2 !== 1'b0) begin
      n_bad++; $display("FAIL wp_clear: got wr=%b want 0", mwr2);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    mrdata2 = 32'hAAAAAAAA;
    rd2 = 2'b10;
    addr2[63:32] = 32'h200;
    for (int c = 1; c <= 8; c++) begin
      tick();
      #1;
      n_cmp++;
      if ({mrd2, rdy2, err2, rdata2} !== {1'b1, (c == 8) ? 2'b10 : 2'b00, c == 8, 32'h0}) begin
        n_bad++; $display("FAIL to_abort c%0d: got rd=%b rdy=%b err=%b data=%h", c, mrd2, rdy2, err2, rdata2);
      end
    end
    tick();
    rd2 = 2'b00;
    #1;
    n_cmp++;
    if ({mrd2, rdy2, err2} !== 4'b0000) begin
      n_bad++; $display("FAIL to_clear: got rd=%b rdy=%b err=%b want 0", mrd2, rdy2, err2);
    end
    rd2 = 2'b10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) mready2 = 1'b1;
      #1;
      n_cmp++;
      if ({rdy2, err2, rdata2} !== {(c == 8) ? 2'b10 : 2'b00, 1'b0, (c == 8) ? 32'hAAAAAAAA : 32'h0}) begin
        n_bad++; $display("FAIL to_coincide c%0d: got rdy=%b err=%b data=%h", c, rdy2, err2, rdata2);
      end
    end
    tick();
    rd2 = 2'b00;
    mready2 = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    do_reset();
    rd2 = 2'b10;
    addr2 = {32'h300, 32'h80};
    tick();
    tick();
    #1;
    n_cmp++;
    if ({mrd2, rdy2} !== 3'b100) begin
      n_bad++; $display("FAIL rm_busy2: got rd=%b rdy=%b want 1 00", mrd2, rdy2);
    end
    rsn = 1'b0;
    tick();
    #1;
    n_cmp++;
    if ({mrd2, mwr2, maddr2, mwdata2, mtype2, rdy2, err2, rdata2} !== '0) begin
      n_bad++; $display("FAIL rm_zero: got rd=%b addr=%h rdy=%b err=%b want all 0", mrd2, maddr2, rdy2, err2);
    end
    rsn = 1'b1;
    rd2 = 2'b11;
    tick();
    #1;
    n_cmp++;
    if ({mrd2, maddr2} !== {1'b1, 32'h80}) begin
      n_bad++; $display("FAIL rm_priority: got rd=%b addr=%h want 1 00000080", mrd2, maddr2);
    end
    mready2 = 1'b1;
    #1;
    n_cmp++;
    if (rdy2 !== 2'b01) begin
      n_bad++; $display("FAIL rm_ready: got %b want 01", rdy2);
    end
    tick();
    rd2 = '0;
    mready2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL tb_watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_write_priority();
    test_timeout();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
